target_reach_detector: RTL

Consumer side of the target handshake in the snake game. It compares the snake head position against the current target address and issues the one-cycle TARGET_REACHED strobe that the target generator uses to load a new target. It also tracks the score and flags a win. It sits between the snake control logic (head position source) and the target generator (target address source).

---
 rtl/target_reach_detector.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/target_reach_detector.sv
// Snake-game target hit detector: issues a one-cycle TARGET_REACHED strobe, keeps score, flags a win.
// Optional macro TARGET_TOLERANCE_EN widens the hit test to a 3x3 window around the target.
module target_reach_detector #(
  parameter int unsigned SCORE_W        = 8,
  parameter int unsigned WIN_SCORE      = 10,
  parameter int unsigned HOLDOFF_CYCLES = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               GAME_ACTIVE,
  input  logic               HEAD_VALID,
  input  logic [7:0]         HEAD_ADDRH,
  input  logic [6:0]         HEAD_ADDRV,
  input  logic [7:0]         TARGET_ADDRH,
  input  logic [6:0]         TARGET_ADDRV,
  output logic               TARGET_REACHED,
  output logic [SCORE_W-1:0] SCORE,
  output logic               WIN,
  output logic               BUSY
);

  localparam int unsigned CNT_W = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_REACHED,
    S_RELOAD,
    S_WON
  } state_e;

  state_e             state_q, state_d;
  logic               target_reached_q, target_reached_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               win_q, win_d;
  logic               busy_q, busy_d;
  logic [7:0]         held_h_q, held_h_d;
  logic [6:0]         held_v_q, held_v_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               match_c;
  logic [SCORE_W-1:0] score_inc_c;

`ifdef TARGET_TOLERANCE_EN
  // Larger-minus-smaller keeps the distance unsigned at the screen edges.
  logic [7:0] dist_h_c;
  logic [6:0] dist_v_c;
  always_comb begin
    dist_h_c = (HEAD_ADDRH >= TARGET_ADDRH) ? (HEAD_ADDRH - TARGET_ADDRH)
                                            : (TARGET_ADDRH - HEAD_ADDRH);
    dist_v_c = (HEAD_ADDRV >= TARGET_ADDRV) ? (HEAD_ADDRV - TARGET_ADDRV)
                                            : (TARGET_ADDRV - HEAD_ADDRV);
    match_c  = (dist_h_c <= 8'd1) && (dist_v_c <= 7'd1);
  end
`else
  assign match_c = (HEAD_ADDRH == TARGET_ADDRH) && (HEAD_ADDRV == TARGET_ADDRV);
`endif

  // Saturating increment: the score never wraps.
  assign score_inc_c = (score_q == {SCORE_W{1'b1}}) ? score_q : (score_q + SCORE_W'(1));

  always_comb begin
    state_d          = state_q;
    target_reached_d = 1'b0;
    score_d          = score_q;
    win_d            = win_q;
    held_h_d         = held_h_q;
    held_v_d         = held_v_q;
    cnt_d            = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (GAME_ACTIVE) begin
          state_d = S_ARMED;
          score_d = '0;
          win_d   = 1'b0;
        end
      end
      S_ARMED: begin
        // A hit in the same cycle GAME_ACTIVE falls still earns its strobe.
        if (HEAD_VALID && match_c) begin
          target_reached_d = 1'b1;
          score_d          = score_inc_c;
          win_d            = win_q | (score_inc_c == SCORE_W'(WIN_SCORE));
          held_h_d         = TARGET_ADDRH;
          held_v_d         = TARGET_ADDRV;
          state_d          = GAME_ACTIVE ? S_REACHED : S_IDLE;
        end else if (!GAME_ACTIVE) begin
          state_d = S_IDLE;
        end
      end
      S_REACHED: begin
        if (!GAME_ACTIVE) begin
          state_d = S_IDLE;
        end else if (win_q) begin
          state_d = S_WON;
        end else begin
          state_d = S_RELOAD;
          cnt_d   = '0;
        end
      end
      S_RELOAD: begin
        // Timeout covers a generator that re-issues the same position.
        if (!GAME_ACTIVE) begin
          state_d = S_IDLE;
        end else if ((TARGET_ADDRH != held_h_q) || (TARGET_ADDRV != held_v_q) ||
                     (cnt_q == CNT_W'(HOLDOFF_CYCLES - 1))) begin
          state_d = S_ARMED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WON: begin
        if (!GAME_ACTIVE) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_REACHED) || (state_d == S_RELOAD);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q          <= S_IDLE;
      target_reached_q <= 1'b0;
      score_q          <= '0;
      win_q            <= 1'b0;
      busy_q           <= 1'b0;
      held_h_q         <= '0;
      held_v_q         <= '0;
      cnt_q            <= '0;
    end else begin
      state_q          <= state_d;
      target_reached_q <= target_reached_d;
      score_q          <= score_d;
      win_q            <= win_d;
      busy_q           <= busy_d;
      held_h_q         <= held_h_d;
      held_v_q         <= held_v_d;
      cnt_q            <= cnt_d;
    end
  end

  assign TARGET_REACHED = target_reached_q;
  assign SCORE          = score_q;
  assign WIN            = win_q;
  assign BUSY           = busy_q;

endmodule
